// File: rtl/fnd_scan_mon.sv
// fnd_scan_mon: receive-side monitor for the multiplexed 7-segment bus.
// It watches the active-low one-hot digit enables and waits for each
// selection to stay stable for SETTLE_CYC samples. It then decodes the
// segment pattern back to a BCD nibble, assembles a six-digit frame and
// publishes that frame with a one-cycle strobe. It also flags scan-order
// faults, collisions and stalls.
//
// Ports:
//   clk, rst      system clock; synchronous active-high reset
//   i_seg         segment pattern {a..g}, active-high (a is the MSB)
//   i_seg_dp      decimal point of the currently selected digit
//   i_seg_enb     digit enables, active-low one-hot (bit k low = digit k)
//   o_digits      published frame, digit k in [4k+3:4k]
//   o_dp          published decimal points, bit k = digit k
//   o_frame_vld   one-cycle strobe when o_digits/o_dp update
//   o_frame_bad   level: last published frame holds an invalid pattern (4'hE)
//   o_seq_err     one-cycle pulse when a partial frame is aborted
//   o_stall       level: no capture for TIMEOUT_CYC cycles
//   o_frame_cnt   published-frame counter, wraps 255 -> 0
module fnd_scan_mon #(
    parameter int SETTLE_CYC  = 16,
    parameter int TIMEOUT_CYC = 20000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  i_seg,
    input  logic        i_seg_dp,
    input  logic [5:0]  i_seg_enb,
    output logic [23:0] o_digits,
    output logic [5:0]  o_dp,
    output logic        o_frame_vld,
    output logic        o_frame_bad,
    output logic        o_seq_err,
    output logic        o_stall,
    output logic [7:0]  o_frame_cnt
);

    localparam int SW = $clog2(SETTLE_CYC + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [SW-1:0] SETTLE_LAST  = SW'(SETTLE_CYC - 1);
    localparam logic [SW-1:0] SETTLE_MAX   = SW'(SETTLE_CYC);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] TIMEOUT_MAX  = TW'(TIMEOUT_CYC);

    typedef enum logic [1:0] {S_HUNT, S_COLLECT, S_PUBLISH} state_t;

    function automatic logic [3:0] seg_decode(input logic [6:0] seg);
        logic [3:0] nib;
        case (seg)
            7'b1111110: nib = 4'h0;
            7'b0110000: nib = 4'h1;
            7'b1101101: nib = 4'h2;
            7'b1111001: nib = 4'h3;
            7'b0110011: nib = 4'h4;
            7'b1011011: nib = 4'h5;
            7'b1011111: nib = 4'h6;
            7'b1110000: nib = 4'h7;
            7'b1111111: nib = 4'h8;
            7'b1110011: nib = 4'h9;
            7'b0000000: nib = 4'hF;
            default:    nib = 4'hE;
        endcase
        return nib;
    endfunction

    // Only meaningful for a one-hot input.
    function automatic logic [2:0] sel_index(input logic [5:0] sel);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 6; i++) begin
            if (sel[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    function automatic logic frame_has_bad(input logic [23:0] frm);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (frm[4*i +: 4] == 4'hE) bad = 1'b1;
        end
        return bad;
    endfunction

    state_t          state;
    logic [2:0]      exp_idx;
    logic [5:0]      enb_prev;
    logic [SW-1:0]   stab_cnt;
    logic [TW-1:0]   to_cnt;
    logic            seq_err_p0;
    logic [23:0]     frm_dig_p0;
    logic [5:0]      frm_dp_p0;

    logic [5:0]      sel;
    logic            sel_gap, sel_one, sel_coll, enb_same;
    logic            capture, timeout_hit, store_en;
    logic [2:0]      cap_idx;
    logic [3:0]      cap_nib;

    always_comb begin
        sel         = ~i_seg_enb;
        sel_gap     = (sel == 6'd0);
        sel_one     = !sel_gap && ((sel & (sel - 6'd1)) == 6'd0);
        sel_coll    = !sel_gap && !sel_one;
        enb_same    = (i_seg_enb == enb_prev);
        // Fires once per assertion: the edge on which the counter reaches
        // SETTLE_CYC. The counter then saturates.
        capture     = sel_one && enb_same && (stab_cnt == SETTLE_LAST);
        cap_idx     = sel_index(sel);
        cap_nib     = seg_decode(i_seg);
        // A capture on the same edge takes priority over the timeout.
        timeout_hit = !capture && (to_cnt == TIMEOUT_LAST);
        store_en    = capture &&
                      (((state == S_HUNT) && (cap_idx == 3'd0)) ||
                       ((state == S_COLLECT) &&
                        ((cap_idx == exp_idx) || (cap_idx == 3'd0))));
    end

    // ---- stage p0: capture into the partial-frame buffer ----
    always_ff @(posedge clk) begin
        if (store_en) begin
            frm_dig_p0[4*cap_idx +: 4] <= cap_nib;
            frm_dp_p0[cap_idx]         <= i_seg_dp;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_HUNT;
            exp_idx     <= 3'd0;
            enb_prev    <= 6'h3F;
            stab_cnt    <= '0;
            to_cnt      <= '0;
            seq_err_p0  <= 1'b0;
            o_digits    <= 24'h000000;
            o_dp        <= 6'b0;
            o_frame_vld <= 1'b0;
            o_frame_bad <= 1'b0;
            o_seq_err   <= 1'b0;
            o_stall     <= 1'b0;
            o_frame_cnt <= 8'd0;
        end else begin
            enb_prev <= i_seg_enb;
            if (!enb_same)
                stab_cnt <= SW'(1);
            else if (stab_cnt != SETTLE_MAX)
                stab_cnt <= stab_cnt + SW'(1);

            if (capture)
                to_cnt <= '0;
            else if (to_cnt != TIMEOUT_MAX)
                to_cnt <= to_cnt + TW'(1);

            if (capture)
                o_stall <= 1'b0;
            else if (timeout_hit)
                o_stall <= 1'b1;

            // ---- stage p1: error pulse and publish ----
            o_seq_err   <= seq_err_p0;
            seq_err_p0  <= 1'b0;
            o_frame_vld <= 1'b0;

            case (state)
                S_HUNT: begin
                    if (capture && (cap_idx == 3'd0)) begin
                        exp_idx <= 3'd1;
                        state   <= S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    if (capture) begin
                        if (cap_idx == exp_idx) begin
                            if (exp_idx == 3'd5) state <= S_PUBLISH;
                            else                 exp_idx <= exp_idx + 3'd1;
                        end else if (cap_idx == 3'd0) begin
                            exp_idx    <= 3'd1;
                            seq_err_p0 <= 1'b1;
                        end else begin
                            seq_err_p0 <= 1'b1;
                            state      <= S_HUNT;
                        end
                    end else if (timeout_hit) begin
                        state <= S_HUNT;
                    end else if (sel_coll) begin
                        seq_err_p0 <= 1'b1;
                        state      <= S_HUNT;
                    end
                end
                S_PUBLISH: begin
                    o_digits    <= frm_dig_p0;
                    o_dp        <= frm_dp_p0;
                    o_frame_bad <= frame_has_bad(frm_dig_p0);
                    o_frame_vld <= 1'b1;
                    o_frame_cnt <= o_frame_cnt + 8'd1;
                    state       <= S_HUNT;
                end
                default: state <= S_HUNT;
            endcase
        end
    end

endmodule

// File: tb/tb_fnd_scan_mon.sv
// Testbench for fnd_scan_mon. Table-driven frames plus directed sequences
// for settle filtering, scan-order errors, collisions, stall and reset.
module tb_fnd_scan_mon;

    localparam int SETTLE = 16;
    localparam int TMO    = 200;
    localparam int HOLD   = 24;
    localparam int GAP    = 4;

    localparam logic [6:0] P0 = 7'b1111110, P1 = 7'b0110000, P2 = 7'b1101101;
    localparam logic [6:0] P3 = 7'b1111001, P4 = 7'b0110011, P5 = 7'b1011011;
    localparam logic [6:0] P6 = 7'b1011111, P7 = 7'b1110000, P8 = 7'b1111111;
    localparam logic [6:0] P9 = 7'b1110011, PB = 7'b0000000, PX = 7'b1000001;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  seg;
    logic        seg_dp;
    logic [5:0]  enb;
    logic [23:0] o_digits;
    logic [5:0]  o_dp;
    logic        o_frame_vld, o_frame_bad, o_seq_err, o_stall;
    logic [7:0]  o_frame_cnt;

    fnd_scan_mon #(.SETTLE_CYC(SETTLE), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst(rst), .i_seg(seg), .i_seg_dp(seg_dp), .i_seg_enb(enb),
        .o_digits(o_digits), .o_dp(o_dp), .o_frame_vld(o_frame_vld),
        .o_frame_bad(o_frame_bad), .o_seq_err(o_seq_err), .o_stall(o_stall),
        .o_frame_cnt(o_frame_cnt)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vld_seen = 0, err_seen = 0, vld_cyc = -1, err_cyc = -1;
    always @(negedge clk) begin
        if (o_frame_vld) begin vld_seen++; vld_cyc = cyc; end
        if (o_seq_err)   begin err_seen++; err_cyc = cyc; end
    end

    int n_cmp = 0, n_bad = 0;
    int last_set, d5_set;

    typedef struct {
        logic [6:0]  pat [6];
        logic [5:0]  dp;
        logic [23:0] exp_dig;
        logic        exp_bad;
    } vec_t;
    vec_t vecs [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Holds the given bus values for exactly n sampling edges.
    task automatic drive(input logic [5:0] e, input logic [6:0] s, input logic d, input int n);
        @(negedge clk);
        enb = e; seg = s; seg_dp = d;
        last_set = cyc;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic digit(input int k, input logic [6:0] s, input logic d, input int n);
        logic [5:0] e;
        e = 6'h3F;
        e[k] = 1'b0;
        drive(e, s, d, n);
    endtask

    task automatic gap(input int n);
        drive(6'h3F, 7'b0, 1'b0, n);
    endtask

    task automatic frame(input vec_t v);
        for (int k = 0; k < 6; k++) begin
            digit(k, v.pat[k], v.dp[k], HOLD);
            if (k == 5) d5_set = last_set;
            gap(GAP);
        end
    endtask

    task automatic chk_frame(input string name, input vec_t v, input int exp_cnt);
        chk({name, ".digits"}, o_digits, v.exp_dig);
        chk({name, ".dp"}, o_dp, v.dp);
        chk({name, ".bad"}, o_frame_bad, v.exp_bad);
        chk({name, ".cnt"}, o_frame_cnt, exp_cnt);
    endtask

    initial begin
        int exp_cnt, v0, e0, s0;
        logic [23:0] held;

        vecs[0].pat = '{P4, P3, P2, P1, PB, PB}; vecs[0].dp = 6'b000010;
        vecs[0].exp_dig = 24'hFF1234; vecs[0].exp_bad = 1'b0;
        vecs[1].pat = '{P5, P6, P7, P8, P9, P0}; vecs[1].dp = 6'b100001;
        vecs[1].exp_dig = 24'h098765; vecs[1].exp_bad = 1'b0;
        vecs[2].pat = '{P0, P1, PX, P9, P8, P7}; vecs[2].dp = 6'b010100;
        vecs[2].exp_dig = 24'h789E10; vecs[2].exp_bad = 1'b1;
        vecs[3].pat = '{P9, P9, P3, P3, PB, P0}; vecs[3].dp = 6'b001000;
        vecs[3].exp_dig = 24'h0F3399; vecs[3].exp_bad = 1'b0;

        rst = 1'b1; enb = 6'h3F; seg = 7'b0; seg_dp = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst.digits", o_digits, 24'h0);
        chk("rst.dp", o_dp, 6'b0);
        chk("rst.vld", o_frame_vld, 1'b0);
        chk("rst.bad", o_frame_bad, 1'b0);
        chk("rst.err", o_seq_err, 1'b0);
        chk("rst.stall", o_stall, 1'b0);
        chk("rst.cnt", o_frame_cnt, 8'd0);

        // Digits other than 0 are ignored while hunting.
        digit(3, P1, 1'b0, HOLD); gap(GAP);
        digit(4, P2, 1'b0, HOLD); gap(GAP);
        chk("hunt.err", err_seen, 0);
        chk("hunt.vld", vld_seen, 0);

        exp_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            v0 = vld_seen;
            frame(vecs[i]);
            exp_cnt++;
            chk($sformatf("vec%0d.pulses", i), vld_seen - v0, 1);
            chk_frame($sformatf("vec%0d", i), vecs[i], exp_cnt);
            if (i == 0) chk("vec0.latency", vld_cyc, d5_set + SETTLE + 1);
        end
        chk("vec.err", err_seen, 0);

        // Short enable glitches (3 and SETTLE-1 samples) never capture.
        v0 = vld_seen; e0 = err_seen;
        digit(0, vecs[1].pat[0], vecs[1].dp[0], HOLD); gap(GAP);
        drive(6'b111101, P3, 1'b0, 3); gap(2);
        digit(1, vecs[1].pat[1], vecs[1].dp[1], HOLD); gap(GAP);
        drive(6'b111011, P3, 1'b0, SETTLE - 1); gap(2);
        for (int k = 2; k < 6; k++) begin
            digit(k, vecs[1].pat[k], vecs[1].dp[k], HOLD); gap(GAP);
        end
        exp_cnt++;
        chk("glitch.err", err_seen - e0, 0);
        chk("glitch.pulses", vld_seen - v0, 1);
        chk_frame("glitch", vecs[1], exp_cnt);

        // Scan order 0,1,3 aborts without touching published outputs.
        v0 = vld_seen; e0 = err_seen; held = o_digits;
        digit(0, P1, 1'b0, HOLD); gap(GAP);
        digit(1, P2, 1'b0, HOLD); gap(GAP);
        digit(3, P3, 1'b0, HOLD); s0 = last_set; gap(GAP);
        chk("seq.err", err_seen - e0, 1);
        chk("seq.err_cyc", err_cyc, s0 + SETTLE + 1);
        chk("seq.digits", o_digits, held);
        chk("seq.vld", vld_seen - v0, 0);
        frame(vecs[0]);
        exp_cnt++;
        chk_frame("seq.next", vecs[0], exp_cnt);

        // Digit 0 mid-frame restarts collection with one error pulse.
        v0 = vld_seen; e0 = err_seen;
        digit(0, P7, 1'b0, HOLD); gap(GAP);
        digit(1, P7, 1'b0, HOLD); gap(GAP);
        frame(vecs[1]);
        exp_cnt++;
        chk("restart.err", err_seen - e0, 1);
        chk("restart.pulses", vld_seen - v0, 1);
        chk_frame("restart", vecs[1], exp_cnt);

        // Collision in COLLECT aborts; collision in HUNT is ignored.
        v0 = vld_seen; e0 = err_seen;
        digit(0, P1, 1'b0, HOLD); gap(GAP);
        digit(1, P1, 1'b0, HOLD); gap(GAP);
        drive(6'b111100, P1, 1'b0, 5); s0 = last_set; gap(GAP);
        chk("coll.err", err_seen - e0, 1);
        chk("coll.err_cyc", err_cyc, s0 + 2);
        chk("coll.vld", vld_seen - v0, 0);
        drive(6'b110011, P1, 1'b0, 5); gap(GAP);
        chk("coll_hunt.err", err_seen - e0, 1);
        frame(vecs[2]);
        exp_cnt++;
        chk_frame("coll.next", vecs[2], exp_cnt);

        // Stall: TIMEOUT cycles after the last capture, cleared by a capture.
        v0 = vld_seen; e0 = err_seen;
        digit(0, P5, 1'b0, SETTLE); s0 = last_set;
        gap(1);
        while (cyc < s0 + SETTLE + TMO - 1) @(negedge clk);
        chk("stall.before", o_stall, 1'b0);
        @(negedge clk);
        chk("stall.set", o_stall, 1'b1);
        digit(1, P5, 1'b0, SETTLE);
        chk("stall.hold", o_stall, 1'b1);
        gap(1);
        chk("stall.clear", o_stall, 1'b0);
        gap(GAP);
        for (int k = 2; k < 6; k++) begin
            digit(k, P5, 1'b0, HOLD); gap(GAP);
        end
        chk("stall.discard", vld_seen - v0, 0);
        chk("stall.err", err_seen - e0, 0);

        // Reset during COLLECT(3) clears everything on that edge.
        chk("pre_rst.cnt", o_frame_cnt, exp_cnt);
        digit(0, P2, 1'b1, HOLD); gap(GAP);
        digit(1, P2, 1'b1, HOLD); gap(GAP);
        digit(2, P2, 1'b1, HOLD);
        rst = 1'b1;
        @(negedge clk);
        chk("mrst.digits", o_digits, 24'h0);
        chk("mrst.dp", o_dp, 6'b0);
        chk("mrst.bad", o_frame_bad, 1'b0);
        chk("mrst.stall", o_stall, 1'b0);
        chk("mrst.cnt", o_frame_cnt, 8'd0);
        rst = 1'b0;
        enb = 6'h3F;
        gap(GAP);
        frame(vecs[3]);
        chk_frame("mrst.next", vecs[3], 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
